// File: rtl/cond_pkg.sv
// Shared constants for the execute-stage condition unit: ARM condition codes,
// NZCV bit positions and flag-write enable bit positions.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memwrite;
    logic valid;
  } m_ctrl_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: decides whether an instruction
// with condition field cond_i executes given the NZCV flags in flags_i.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_stage.sv
// Execute-stage condition unit: owns the NZCV flag register, gates the E-stage
// write/branch controls on the condition result and registers them into M.
module cond_stage
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       StallM,
  input  logic       FlushM,
  input  logic       ValidE,
  input  logic [3:0] CondE,
  input  logic [3:0] FlagsALU,
  input  logic [1:0] FlagWriteE,
  input  logic       PCSE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       NoWriteE,
  output logic       CondExE,
  output logic [3:0] Flags,
  output logic       PCSrcM,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       ValidM
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  m_ctrl_t    m_q, m_d;
  logic       cond_pass;

  assign Flags = {nz_q, cv_q};

  // Condition is judged against the architectural flags only; no ALU bypass.
  cond_eval u_cond_eval (
    .cond_i  (CondE),
    .flags_i (Flags),
    .pass_o  (cond_pass)
  );

  assign CondExE = ValidE & cond_pass;

  // Stall freezes the flags even under flush; flush alone only squashes M.
  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (!StallM && CondExE) begin
      if (FlagWriteE[FLAGW_NZ]) nz_d = FlagsALU[FLAG_N:FLAG_Z];
      if (FlagWriteE[FLAGW_CV]) cv_d = FlagsALU[FLAG_C:FLAG_V];
    end
  end

  always_comb begin
    m_d = m_q;
    if (FlushM) begin
      m_d = '0;
    end else if (!StallM) begin
      m_d.pcsrc    = PCSE & CondExE;
      m_d.regwrite = RegWriteE & ~NoWriteE & CondExE;
      m_d.memwrite = MemWriteE & CondExE;
      m_d.valid    = ValidE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
      m_q  <= '0;
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
      m_q  <= m_d;
    end
  end

  assign PCSrcM    = m_q.pcsrc;
  assign RegWriteM = m_q.regwrite;
  assign MemWriteM = m_q.memwrite;
  assign ValidM    = m_q.valid;

endmodule

// File: tb/tb_cond_stage.sv
// Self-checking bench for cond_stage: vector table, full cond x flags sweep,
// and directed stall/flush/bubble/reset sequences with an M-stage scoreboard.
module tb_cond_stage;

  logic       clk = 1'b0;
  logic       reset, StallM, FlushM, ValidE;
  logic [3:0] CondE, FlagsALU;
  logic [1:0] FlagWriteE;
  logic       PCSE, RegWriteE, MemWriteE, NoWriteE;
  logic       CondExE;
  logic [3:0] Flags;
  logic       PCSrcM, RegWriteM, MemWriteM, ValidM;

  always #5 clk = ~clk;

  cond_stage dut (
    .clk        (clk),
    .reset      (reset),
    .StallM     (StallM),
    .FlushM     (FlushM),
    .ValidE     (ValidE),
    .CondE      (CondE),
    .FlagsALU   (FlagsALU),
    .FlagWriteE (FlagWriteE),
    .PCSE       (PCSE),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .NoWriteE   (NoWriteE),
    .CondExE    (CondExE),
    .Flags      (Flags),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ValidM     (ValidM)
  );

  typedef struct packed {
    logic pcs;
    logic rw;
    logic mw;
    logic valid;
  } mexp_t;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       exp;
  } vec_t;

  mexp_t      sb[$];
  mexp_t      mcur;
  logic [3:0] mflags;
  int         checks = 0;
  int         failures = 0;
  logic       ps;
  vec_t       vecs[16];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // One E-stage cycle: drive, check combinational outputs, predict M, clock, compare.
  task automatic cycle(input logic rst, input logic v, input logic [3:0] c,
                       input logic [3:0] fa, input logic [1:0] fw, input logic p,
                       input logic r, input logic m, input logic nw, input logic st,
                       input logic fl, output logic pass_seen);
    mexp_t e, g;
    logic  ep;
    reset = rst; ValidE = v; CondE = c; FlagsALU = fa; FlagWriteE = fw;
    PCSE = p; RegWriteE = r; MemWriteE = m; NoWriteE = nw; StallM = st; FlushM = fl;
    #1;
    ep = v & ref_pass(c, mflags);
    pass_seen = CondExE;
    check("CondExE", {7'd0, CondExE}, {7'd0, ep});
    check("Flags", {4'd0, Flags}, {4'd0, mflags});
    if (rst || fl) e = '0;
    else if (st) e = mcur;
    else e = '{pcs: p & ep, rw: r & ~nw & ep, mw: m & ep, valid: v};
    sb.push_back(e);
    mcur = e;
    if (rst) mflags = 4'b0000;
    else if (!st && ep) begin
      if (fw[1]) mflags[3:2] = fa[3:2];
      if (fw[0]) mflags[1:0] = fa[1:0];
    end
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("Mregs", {4'd0, PCSrcM, RegWriteM, MemWriteM, ValidM}, {4'd0, g});
    check("FlagsNext", {4'd0, Flags}, {4'd0, mflags});
  endtask

  // Load the flag register via an always-executing flag-setting op.
  task automatic set_flags(input logic [3:0] f);
    logic dummy;
    cycle(1'b0, 1'b1, 4'hE, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, dummy);
  endtask

  initial begin
    vecs[0]  = '{4'h0, 4'b0100, 1'b1};
    vecs[1]  = '{4'h1, 4'b0100, 1'b0};
    vecs[2]  = '{4'h2, 4'b0010, 1'b1};
    vecs[3]  = '{4'h3, 4'b0010, 1'b0};
    vecs[4]  = '{4'h4, 4'b1000, 1'b1};
    vecs[5]  = '{4'h6, 4'b0001, 1'b1};
    vecs[6]  = '{4'h8, 4'b0010, 1'b1};
    vecs[7]  = '{4'h8, 4'b0110, 1'b0};
    vecs[8]  = '{4'h9, 4'b0000, 1'b1};
    vecs[9]  = '{4'hA, 4'b1001, 1'b1};
    vecs[10] = '{4'hB, 4'b1000, 1'b1};
    vecs[11] = '{4'hC, 4'b0000, 1'b1};
    vecs[12] = '{4'hC, 4'b0100, 1'b0};
    vecs[13] = '{4'hD, 4'b0001, 1'b1};
    vecs[14] = '{4'hE, 4'b0000, 1'b1};
    vecs[15] = '{4'hF, 4'b1111, 1'b1};

    reset = 1'b1; StallM = 1'b0; FlushM = 1'b0; ValidE = 1'b0; CondE = 4'h0;
    FlagsALU = 4'h0; FlagWriteE = 2'b00; PCSE = 1'b0; RegWriteE = 1'b0;
    MemWriteE = 1'b0; NoWriteE = 1'b0;
    mflags = 4'b0000;
    mcur = '0;
    @(posedge clk);
    #1;

    // Reset state
    cycle(1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps);
    check("reset_outs", {Flags, PCSrcM, RegWriteM, MemWriteM, ValidM}, 8'h00);

    // SUBS sets Z; following EQ passes, NE with writes fails
    cycle(1'b0, 1'b1, 4'hE, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ps);
    check("subs_flags", {4'd0, Flags}, 8'h04);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps);
    check("eq_after_subs", {7'd0, ps}, 8'h01);
    cycle(1'b0, 1'b1, 4'h1, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ps);
    check("ne_fail", {7'd0, ps}, 8'h00);
    check("ne_m", {4'd0, PCSrcM, RegWriteM, MemWriteM, ValidM}, 8'h01);
    check("ne_flags", {4'd0, Flags}, 8'h04);

    // Independent NZ / CV halves
    cycle(1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps);
    cycle(1'b0, 1'b1, 4'hE, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps);
    check("nz_half", {4'd0, Flags}, 8'h08);
    cycle(1'b0, 1'b1, 4'hE, 4'b0010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps);
    check("cv_half", {4'd0, Flags}, 8'h0A);

    // CMP: register write suppressed, flags updated
    cycle(1'b0, 1'b1, 4'hE, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ps);
    check("cmp_rw", {7'd0, RegWriteM}, 8'h00);
    check("cmp_flags", {4'd0, Flags}, 8'h06);

    // Stall holds M and flags; stall+flush zeroes M but holds flags; flush alone updates flags
    cycle(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ps);
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 1'b1, 4'hE, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ps);
    check("stall_m", {4'd0, PCSrcM, RegWriteM, MemWriteM, ValidM}, 8'h0F);
    check("stall_flags", {4'd0, Flags}, 8'h06);
    cycle(1'b0, 1'b1, 4'hE, 4'b1001, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ps);
    check("stflush_m", {4'd0, PCSrcM, RegWriteM, MemWriteM, ValidM}, 8'h00);
    check("stflush_flags", {4'd0, Flags}, 8'h06);
    cycle(1'b0, 1'b1, 4'hE, 4'b1001, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ps);
    check("flush_flags", {4'd0, Flags}, 8'h09);

    // Bubble: nothing executes
    cycle(1'b0, 1'b0, 4'hE, 4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps);
    check("bubble_pass", {7'd0, ps}, 8'h00);
    check("bubble_pcs", {7'd0, PCSrcM}, 8'h00);
    check("bubble_flags", {4'd0, Flags}, 8'h09);

    // Reset mid-sequence overrides stall; then EQ fails, NE passes
    set_flags(4'b0100);
    cycle(1'b0, 1'b1, 4'hE, 4'b1111, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ps);
    cycle(1'b1, 1'b1, 4'hE, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ps);
    check("midreset", {Flags, PCSrcM, RegWriteM, MemWriteM, ValidM}, 8'h00);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps);
    check("post_reset_eq", {7'd0, ps}, 8'h00);
    cycle(1'b0, 1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps);
    check("post_reset_ne", {7'd0, ps}, 8'h01);

    // Hand-computed vector table
    for (int i = 0; i < 16; i++) begin
      set_flags(vecs[i].flags);
      cycle(1'b0, 1'b1, vecs[i].cond, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ps);
      check($sformatf("table%0d", i), {7'd0, ps}, {7'd0, vecs[i].exp});
    end

    // Full sweep: 16 flag values x 16 conditions against the reference model
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++)
        cycle(1'b0, 1'b1, 4'(c), 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ps);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
